// File: rtl/tx_frame_arbiter.sv
// Shared L2 transmit arbiter: grants one of four frame sources (ARP on index 3 has priority),
// forwards its byte stream with one register stage, and enforces an inter-frame gap.
module tx_frame_arbiter #(
    parameter int IFG_CYCLES  = 12,
    parameter int SOF_TIMEOUT = 64,
    parameter int MAX_LEN     = 1536
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LINK_UP,
    input  logic [3:0]  ReqIn,
    input  logic [3:0]  ValIn,
    input  logic [3:0]  SoFIn,
    input  logic [3:0]  EoFIn,
    input  logic [31:0] DataIn,
    output logic [3:0]  ReqConfirm,
    output logic        ValOut,
    output logic        SoFOut,
    output logic        EoFOut,
    output logic [7:0]  DataOut,
    output logic        ErrOut,
    output logic        Busy,
    output logic [1:0]  ActiveIdx
);
    localparam int BW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(SOF_TIMEOUT + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam logic [BW-1:0] LEN_LAST = BW'(MAX_LEN - 1);
    localparam logic [BW-1:0] BYTE_ONE = BW'(1);
    localparam logic [TW-1:0] TO_LAST  = TW'(SOF_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t        stateReg;
    logic [1:0]    lastUser;
    logic [BW-1:0] byteCnt;
    logic [TW-1:0] timeoutCnt;
    logic [GW-1:0] gapCnt;

    logic [7:0] laneData [4];
    logic [7:0] selByte;
    logic       selVal, selSoF, selEoF, selReq;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            assign laneData[gi] = DataIn[8*gi +: 8];
        end
    endgenerate

    // ActiveIdx is only meaningful while GRANT/XFER; elsewhere the lane is not looked at.
    assign selByte = laneData[ActiveIdx];
    assign selVal  = ValIn[ActiveIdx];
    assign selSoF  = SoFIn[ActiveIdx];
    assign selEoF  = EoFIn[ActiveIdx];
    assign selReq  = ReqIn[ActiveIdx];

    function automatic logic [1:0] rrStep(input logic [1:0] base);
        return (base == 2'd2) ? 2'd0 : base + 2'd1;
    endfunction

    logic [1:0] cand0, cand1, cand2, pickIdx;
    logic       pickValid;

    assign cand0 = rrStep(lastUser);
    assign cand1 = rrStep(cand0);
    assign cand2 = rrStep(cand1);

    always_comb begin
        pickValid = 1'b1;
        pickIdx   = 2'd3;
        if (ReqIn[3])          pickIdx = 2'd3;
        else if (ReqIn[cand0]) pickIdx = cand0;
        else if (ReqIn[cand1]) pickIdx = cand1;
        else if (ReqIn[cand2]) pickIdx = cand2;
        else                   pickValid = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg   <= IDLE;
            lastUser   <= 2'd2;
            byteCnt    <= '0;
            timeoutCnt <= '0;
            gapCnt     <= '0;
            ReqConfirm <= 4'b0000;
            ValOut     <= 1'b0;
            SoFOut     <= 1'b0;
            EoFOut     <= 1'b0;
            DataOut    <= 8'h00;
            ErrOut     <= 1'b0;
            Busy       <= 1'b0;
            ActiveIdx  <= 2'd0;
        end else begin
            ValOut  <= 1'b0;
            SoFOut  <= 1'b0;
            EoFOut  <= 1'b0;
            ErrOut  <= 1'b0;
            DataOut <= 8'h00;
            gapCnt  <= '0;
            case (stateReg)
                IDLE: begin
                    if (LINK_UP && pickValid) begin
                        stateReg   <= GRANT;
                        ReqConfirm <= 4'b0001 << pickIdx;
                        ActiveIdx  <= pickIdx;
                        byteCnt    <= '0;
                        timeoutCnt <= '0;
                        Busy       <= 1'b1;
                        if (pickIdx != 2'd3) lastUser <= pickIdx;
                    end
                end
                GRANT: begin
                    timeoutCnt <= timeoutCnt + TO_ONE;
                    if (selVal && selSoF) begin
                        ValOut  <= 1'b1;
                        SoFOut  <= 1'b1;
                        DataOut <= selByte;
                        byteCnt <= BYTE_ONE;
                        if (selEoF) begin
                            EoFOut     <= 1'b1;
                            ReqConfirm <= 4'b0000;
                            stateReg   <= GAP;
                        end else begin
                            stateReg <= XFER;
                        end
                    end else if (!selReq) begin
                        ReqConfirm <= 4'b0000;
                        Busy       <= 1'b0;
                        stateReg   <= IDLE;
                    end else if (timeoutCnt == TO_LAST) begin
                        ReqConfirm <= 4'b0000;
                        ErrOut     <= 1'b1;
                        stateReg   <= GAP;
                    end
                end
                XFER: begin
                    // Link loss closes the frame without a data byte, even if one is offered.
                    if (!LINK_UP) begin
                        EoFOut     <= 1'b1;
                        ErrOut     <= 1'b1;
                        ReqConfirm <= 4'b0000;
                        stateReg   <= GAP;
                    end else if (selVal) begin
                        ValOut  <= 1'b1;
                        DataOut <= selByte;
                        byteCnt <= byteCnt + BYTE_ONE;
                        if (selEoF || byteCnt == LEN_LAST) begin
                            EoFOut     <= 1'b1;
                            ErrOut     <= !selEoF;
                            ReqConfirm <= 4'b0000;
                            stateReg   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        Busy     <= 1'b0;
                        stateReg <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + GAP_ONE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: table-driven arbitration vectors plus frame-level sequences
// whose forwarded bytes are checked against a scoreboard queue.
module tb_tx_frame_arbiter;
    logic        Clk = 1'b0;
    logic        Rst, LINK_UP;
    logic [3:0]  ReqIn, ValIn, SoFIn, EoFIn;
    logic [31:0] DataIn;
    logic [3:0]  ReqConfirm;
    logic        ValOut, SoFOut, EoFOut, ErrOut, Busy;
    logic [7:0]  DataOut;
    logic [1:0]  ActiveIdx;

    tx_frame_arbiter dut (
        .Clk(Clk), .Rst(Rst), .LINK_UP(LINK_UP), .ReqIn(ReqIn), .ValIn(ValIn),
        .SoFIn(SoFIn), .EoFIn(EoFIn), .DataIn(DataIn), .ReqConfirm(ReqConfirm),
        .ValOut(ValOut), .SoFOut(SoFOut), .EoFOut(EoFOut), .DataOut(DataOut),
        .ErrOut(ErrOut), .Busy(Busy), .ActiveIdx(ActiveIdx)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       link;
        logic [3:0] expConfirm;
        logic [1:0] expIdx;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs [10];
    int   errors = 0, checks = 0;
    int   valCnt = 0, sofCnt = 0, eofCnt = 0, errCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and forwarded bytes are
    // matched against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        if (ValOut) begin
            valCnt++;
            if (sbq.size() == 0) begin
                check("unexpected_valout", 32'(ValOut), 0);
            end else begin
                e = sbq.pop_front();
                check("dataout", 32'(DataOut), 32'(e.data));
                check("sofout", 32'(SoFOut), 32'(e.sof));
                check("eofout", 32'(EoFOut), 32'(e.eof));
            end
        end
        if (SoFOut) sofCnt++;
        if (EoFOut) eofCnt++;
        if (ErrOut) errCnt++;
    endtask

    task automatic doReset();
        Rst = 1'b1; LINK_UP = 1'b1; ReqIn = 4'b0; ValIn = 4'b0;
        SoFIn = 4'b0; EoFIn = 4'b0; DataIn = 32'h0;
        step();
        step();
        Rst = 1'b0;
        sbq.delete();
    endtask

    task automatic sendFrame(input int src, input int len, input bit withEof);
        logic [3:0]  m;
        logic [31:0] d;
        exp_t        e;
        m = 4'b0001 << src;
        for (int i = 0; i < len; i++) begin
            if (i % 7 == 3) begin
                DataIn = $urandom;
                ValIn  = 4'($urandom) & ~m;
                SoFIn  = 4'($urandom) & ~m;
                EoFIn  = 4'($urandom) & ~m;
                step();
            end
            d      = $urandom;
            DataIn = d;
            ValIn  = (4'($urandom) & ~m) | m;
            SoFIn  = (4'($urandom) & ~m) | ((i == 0 || i == 5) ? m : 4'b0);
            EoFIn  = (4'($urandom) & ~m) | ((withEof && i == len - 1) ? m : 4'b0);
            e.data = d[8*src +: 8];
            e.sof  = (i == 0);
            e.eof  = withEof && (i == len - 1);
            sbq.push_back(e);
            step();
        end
        ValIn = 4'b0; SoFIn = 4'b0; EoFIn = 4'b0; DataIn = 32'h0;
        $display("frame src=%0d len=%0d eof=%0d", src, len, withEof);
    endtask

    task automatic waitGrant(output int idx, input int budget);
        idx = -1;
        for (int n = 0; n < budget; n++) begin
            if (ReqConfirm != 4'b0) break;
            step();
        end
        if (ReqConfirm == 4'b0) check("grant_wait_expired", 0, 1);
        for (int k = 0; k < 4; k++) if (ReqConfirm[k]) idx = k;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g, hi, bz, gr, v0, s0, e0, er0;
        int expOrder [7];
        logic [31:0] d;
        exp_t e;

        // Sequential vectors: round-robin pointer starts so that source 0 is searched first.
        vecs[0] = '{4'b0001, 1'b1, 4'b0001, 2'd0};
        vecs[1] = '{4'b0111, 1'b1, 4'b0010, 2'd1};
        vecs[2] = '{4'b0111, 1'b1, 4'b0100, 2'd2};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        vecs[4] = '{4'b0101, 1'b1, 4'b0001, 2'd0};
        vecs[5] = '{4'b0101, 1'b1, 4'b0100, 2'd2};
        vecs[6] = '{4'b1111, 1'b0, 4'b0000, 2'd0};
        vecs[7] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[8] = '{4'b1000, 1'b1, 4'b1000, 2'd3};
        vecs[9] = '{4'b0110, 1'b1, 4'b0010, 2'd1};

        doReset();
        check("reset_outputs", {ReqConfirm, ValOut, SoFOut, EoFOut, DataOut, ErrOut, Busy, ActiveIdx}, 0);

        for (int i = 0; i < 10; i++) begin
            ReqIn = vecs[i].req; LINK_UP = vecs[i].link;
            step();
            check($sformatf("vec%0d_confirm", i), 32'(ReqConfirm), 32'(vecs[i].expConfirm));
            check($sformatf("vec%0d_busy", i), 32'(Busy), 32'(vecs[i].expConfirm != 4'b0));
            if (vecs[i].expConfirm != 4'b0)
                check($sformatf("vec%0d_idx", i), 32'(ActiveIdx), 32'(vecs[i].expIdx));
            ReqIn = 4'b0; LINK_UP = 1'b1;
            step();
            check($sformatf("vec%0d_release", i), 32'({ReqConfirm, ErrOut, Busy}), 0);
            $display("vector %0d req=%b link=%b confirm=%b", i, vecs[i].req, vecs[i].link, vecs[i].expConfirm);
        end

        // Single 60-byte frame from source 0, then the enforced gap.
        doReset();
        ReqIn = 4'b0001;
        step();
        check("single_confirm", 32'(ReqConfirm), 1);
        v0 = valCnt; s0 = sofCnt; e0 = eofCnt;
        sendFrame(0, 60, 1'b1);
        check("single_drop", 32'(ReqConfirm), 0);
        check("single_val_count", valCnt - v0, 60);
        check("single_sof_count", sofCnt - s0, 1);
        check("single_eof_count", eofCnt - e0, 1);
        for (int n = 1; n <= 12; n++) begin
            step();
            check("gap_confirm", 32'(ReqConfirm), 0);
            check("gap_busy", 32'(Busy), 32'(n < 12));
        end
        step();
        check("regrant_after_gap", 32'(ReqConfirm), 1);
        ReqIn = 4'b0;
        step();

        // Fairness with ARP interjection during the second frame of source 1.
        doReset();
        expOrder = '{0, 1, 2, 0, 1, 3, 2};
        ReqIn = 4'b0111;
        for (int f = 0; f < 7; f++) begin
            waitGrant(g, 40);
            check($sformatf("grant_order%0d", f), g, expOrder[f]);
            if (f == 4) ReqIn = 4'b1111;
            if (g >= 0) sendFrame(g, 10, 1'b1);
            if (f == 5) ReqIn = 4'b0111;
        end
        ReqIn = 4'b0;
        check("fair_sb_empty", sbq.size(), 0);

        // Source 2 is granted but never starts a frame.
        doReset();
        ReqIn = 4'b0100;
        step();
        check("to_confirm", 32'(ReqConfirm), 4);
        hi = 1; er0 = errCnt; v0 = valCnt;
        for (int n = 0; n < 200 && ReqConfirm != 4'b0; n++) begin
            step();
            if (ReqConfirm != 4'b0) hi++;
        end
        check("to_grant_cycles", hi, 64);
        check("to_err", 32'(ErrOut), 1);
        ReqIn = 4'b0;
        bz = 0;
        for (int n = 0; n < 30 && Busy; n++) begin
            bz++;
            step();
        end
        check("to_busy_cycles", bz, 12);
        check("to_err_pulses", errCnt - er0, 1);
        check("to_no_valout", valCnt - v0, 0);

        // Oversize frame: 1600 bytes offered, the 1536th closes it with an error.
        doReset();
        ReqIn = 4'b0001;
        step();
        er0 = errCnt; v0 = valCnt;
        for (int i = 0; i < 1600; i++) begin
            d = $urandom;
            DataIn = d; ValIn = 4'b0001;
            SoFIn = (i == 0) ? 4'b0001 : 4'b0000;
            EoFIn = 4'b0;
            if (i < 1536) begin
                e.data = d[7:0]; e.sof = (i == 0); e.eof = (i == 1535);
                sbq.push_back(e);
            end
            step();
            if (i == 1535) begin
                check("oversize_err", 32'(ErrOut), 1);
                check("oversize_eof", 32'(EoFOut), 1);
                ReqIn = 4'b0;
            end
        end
        ValIn = 4'b0; SoFIn = 4'b0; DataIn = 32'h0;
        check("oversize_val_count", valCnt - v0, 1536);
        check("oversize_err_pulses", errCnt - er0, 1);
        check("oversize_sb_empty", sbq.size(), 0);
        $display("frame src=0 len=1600 oversize");

        // Link loss after 20 bytes, then no grant while the link is down.
        doReset();
        ReqIn = 4'b0010;
        step();
        check("link_confirm", 32'(ReqConfirm), 2);
        sendFrame(1, 20, 1'b0);
        LINK_UP = 1'b0; ValIn = 4'b0010; DataIn = $urandom;
        step();
        check("link_valout", 32'(ValOut), 0);
        check("link_eof", 32'(EoFOut), 1);
        check("link_err", 32'(ErrOut), 1);
        check("link_drop", 32'(ReqConfirm), 0);
        ValIn = 4'b0; ReqIn = 4'b1111;
        gr = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (ReqConfirm != 4'b0) gr++;
        end
        check("link_down_grants", gr, 0);
        LINK_UP = 1'b1;
        step();
        check("link_up_grant", 32'(ReqConfirm), 8);
        ReqIn = 4'b0;
        step();

        // Reset in the middle of an ARP frame.
        doReset();
        ReqIn = 4'b1000;
        step();
        sendFrame(3, 5, 1'b0);
        Rst = 1'b1; ValIn = 4'b1000; DataIn = 32'hA5A5A5A5;
        step();
        check("rst_outputs", {ReqConfirm, ValOut, SoFOut, EoFOut, DataOut, ErrOut, Busy, ActiveIdx}, 0);
        Rst = 1'b0; ValIn = 4'b0; DataIn = 32'h0; ReqIn = 4'b0110;
        step();
        check("rst_first_grant", 32'(ReqConfirm), 2);
        check("rst_first_idx", 32'(ActiveIdx), 1);
        ReqIn = 4'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
Sequences access to the shared L2 transmit path for four frame sources: three user UDP channels (0..2) and the ARP responder (3). It grants one requester at a time, forwards that requester's byte stream to the TX framer input, and inserts an inter-frame gap after each frame. It also aborts stalled, oversize or link-lost frames. It sits between the per-channel frame builders / ARP_L2 and the RGMII TX serializer, on the RX-recovered clock domain.

Parameters:
IFG_CYCLES, 12, idle Clk cycles enforced after each frame end or abort before the next grant
SOF_TIMEOUT, 64, cycles a granted requester has to present SoF before the grant is revoked
MAX_LEN, 1536, maximum bytes per frame (Val cycles, SoF byte included)

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  synchronous reset, active-high
LINK_UP  in  1  PHY link status; no new grant while 0
ReqIn  in  4  per-source transmit request; bit 3 = ARP
ValIn  in  4  per-source byte valid
SoFIn  in  4  per-source start-of-frame, qualified by ValIn
EoFIn  in  4  per-source end-of-frame, qualified by ValIn
DataIn  in  32  per-source byte; source k on bits [8k+7:8k]
ReqConfirm  out  4  one-hot grant
ValOut  out  1  byte valid to TX framer
SoFOut  out  1  start-of-frame
EoFOut  out  1  end-of-frame
DataOut  out  8  byte
ErrOut  out  1  one-cycle pulse on abort
Busy  out  1  1 in any state other than IDLE
ActiveIdx  out  2  index of current/last granted source

Behaviour:
- Reset values: all outputs 0. State IDLE. Round-robin pointer set so that source 0 is searched first. Counters 0.
- States: IDLE, GRANT, XFER, GAP.
- IDLE: if LINK_UP=1 and ReqIn!=0, select a source and move to GRANT. ReqConfirm[k]=1 and ActiveIdx=k from the next cycle.
- Selection: ReqIn[3] always wins. Otherwise round-robin over 0..2, starting after the last granted user source. The pointer updates only on user-source grants.
- GRANT: the timeout counter increments each cycle.
  - ValIn[k]&SoFIn[k] -> go to XFER; this byte is forwarded.
  - ReqIn[k] falls before SoF -> go to IDLE, drop grant, no ErrOut, no gap.
  - Counter reaches SOF_TIMEOUT -> drop grant, ErrOut pulse, go to GAP.
- Datapath: registered, fixed 1-cycle latency.
  - ValOut/DataOut/EoFOut follow source k only while in GRANT(SoF cycle)/XFER.
  - SoFOut is asserted only for the first byte; a repeated SoF inside XFER is passed as data with SoFOut=0.
  - Non-granted inputs are ignored. ValOut=0 whenever ValIn[k]=0.
- XFER: the byte counter increments per ValIn[k].
  - ValIn[k]&EoFIn[k] -> that byte is output with EoFOut=1; grant drops the next cycle; go to GAP.
  - Byte number MAX_LEN arrives without EoF -> that byte is output with EoFOut=1 and ErrOut=1; grant drops; go to GAP. The rest of the source frame is ignored.
  - LINK_UP falls -> the next cycle outputs ValOut=0, EoFOut=1, ErrOut=1; grant drops; go to GAP.
- GAP: ReqConfirm=0. Count IFG_CYCLES cycles, then go to IDLE. Requests pending during GAP are held, not lost. Arbitration happens in IDLE, so the minimum spacing between frames is IFG_CYCLES+2 cycles.
- The byte counter and timeout counter clear on every entry to GRANT.
- ReqIn[k] deasserted during XFER is ignored; the frame completes.
- Rst during any state: everything returns to reset values on the next cycle. No EoF is emitted for the cut frame.

Test Plan:
- Single requester: ReqIn=0001, 60-byte frame with SoF on byte 1 and EoF on byte 60 -> ReqConfirm=0001 one cycle after the request. DataOut equals the input delayed 1 cycle. 60 ValOut cycles, SoFOut/EoFOut each exactly once. ReqConfirm=0 for 12 cycles after EoF.
- Fairness and ARP priority: ReqIn=0111 held, each frame 10 bytes -> grant order 0,1,2,0. Then assert ReqIn[3] during frame 1 -> next grant is 3, after which round-robin resumes at 2.
- SoF timeout: grant source 2, never send SoF -> ReqConfirm drops after 64 cycles, ErrOut is a 1-cycle pulse, Busy stays high through 12 gap cycles, ValOut never asserted.
- Oversize: MAX_LEN=1536, send 1600 bytes with no EoF -> EoFOut=1 and ErrOut=1 on output byte 1536, no ValOut afterwards.
- Link loss at byte 20 -> next cycle ValOut=0, EoFOut=1, ErrOut=1. With LINK_UP=0 and ReqIn=1111, no grant issues until LINK_UP returns.
- Rst asserted mid-XFER -> all outputs 0 the next cycle. After release with ReqIn=0110, the first grant goes to source 1.
